// File: rtl/spi_adc_capture_pkg.sv
// Shared definitions for the SPI ADC capture block: FSM encoding, counter sizing
// and the parameter legality rule used at elaboration.
package spi_adc_capture_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SETUP = 2'd1,
      S_SHIFT = 2'd2,
      S_GAP   = 2'd3
   } state_t;

   // Counter width for values 0..n-1, never narrower than one bit.
   function automatic int cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic bit params_ok(input int div, input int data, input int pre,
                                    input int post, input int gap);
      return (div >= 1) && (data >= 1) && (data <= 16) && (pre >= 0) && (post >= 0) &&
             (pre + data + post <= 32) && (gap >= 1);
   endfunction

endpackage

// File: rtl/spi_adc_capture_if.sv
// Control, serial and result signals of spi_adc_capture; slave is the block side,
// master is whoever drives the requests and the device data.
interface spi_adc_capture_if #(parameter int DATA_BITS = 8);
   logic                 i_enable;
   logic                 i_single;
   logic                 o_sck;
   logic                 o_cs;
   logic                 i_sdo;
   logic [DATA_BITS-1:0] o_value;
   logic                 o_valid;
   logic                 o_frame_err;
   logic [7:0]           o_err_count;

   modport slave (
      input  i_enable, i_single, i_sdo,
      output o_sck, o_cs, o_value, o_valid, o_frame_err, o_err_count
   );

   modport master (
      output i_enable, i_single, i_sdo,
      input  o_sck, o_cs, o_value, o_valid, o_frame_err, o_err_count
   );
endinterface

// File: rtl/spi_sck_gen.sv
// Serial clock generator: while enabled, DIV_FACTOR cycles low then DIV_FACTOR high,
// starting low on the first enabled cycle; idles high.
module spi_sck_gen
   import spi_adc_capture_pkg::*;
#(
   parameter int DIV_FACTOR = 2
) (
   input  logic i_system_clock,
   input  logic i_aresetn,
   input  logic i_en,
   output logic o_sck,
   output logic o_rise,
   output logic o_hi_end
);

   localparam int            CW   = cw(DIV_FACTOR);
   localparam logic [CW-1:0] LAST = CW'(DIV_FACTOR - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sck_q, sck_d;
   logic          half_end;

   assign half_end = (cnt_q == LAST);

   // Parking the counter at LAST makes the first enabled cycle drop sck.
   always_comb begin
      cnt_d = cnt_q;
      sck_d = sck_q;
      if (!i_en) begin
         sck_d = 1'b1;
         cnt_d = LAST;
      end else if (half_end) begin
         sck_d = ~sck_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge i_system_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         cnt_q <= LAST;
         sck_q <= 1'b1;
      end else begin
         cnt_q <= cnt_d;
         sck_q <= sck_d;
      end
   end

   // Strobes depend only on state; the caller qualifies them with its own phase.
   assign o_sck    = sck_q;
   assign o_rise   = half_end & ~sck_q;
   assign o_hi_end = half_end & sck_q;

endmodule

// File: rtl/spi_adc_capture.sv
// SPI ADC frame capture: runs CS/SCK framing, shifts in the payload MSB first and
// reports good frames on o_value/o_valid and bad framing on o_frame_err/o_err_count.
module spi_adc_capture
   import spi_adc_capture_pkg::*;
#(
   parameter int DIV_FACTOR   = 2,
   parameter int PREFIX_BITS  = 3,
   parameter int DATA_BITS    = 8,
   parameter int POSTFIX_BITS = 5,
   parameter int GAP_CYCLES   = 4
) (
   input logic              i_system_clock,
   input logic              i_aresetn,
   spi_adc_capture_if.slave bus
);

   localparam int N  = PREFIX_BITS + DATA_BITS + POSTFIX_BITS;
   localparam int BW = cw(N);
   localparam int CW = cw((DIV_FACTOR > GAP_CYCLES) ? DIV_FACTOR : GAP_CYCLES);

   if (!params_ok(DIV_FACTOR, DATA_BITS, PREFIX_BITS, POSTFIX_BITS, GAP_CYCLES)) begin : g_param_check
      $error("spi_adc_capture: illegal parameter set");
   end

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [BW-1:0]        bit_q, bit_d;
   logic [DATA_BITS-1:0] shreg_q, shreg_d;
   logic [DATA_BITS-1:0] value_q, value_d;
   logic [7:0]           errc_q, errc_d;
   logic                 bad_q, bad_d;
   logic                 cs_q, cs_d;
   logic                 valid_q, valid_d;
   logic                 ferr_q, ferr_d;
   logic                 launch, in_data;
   logic                 sck_en, sck_rise, sck_hi_end;

   spi_sck_gen #(.DIV_FACTOR(DIV_FACTOR)) u_sck (
      .i_system_clock (i_system_clock),
      .i_aresetn      (i_aresetn),
      .i_en           (sck_en),
      .o_sck          (bus.o_sck),
      .o_rise         (sck_rise),
      .o_hi_end       (sck_hi_end)
   );

   assign in_data = (int'(bit_q) >= PREFIX_BITS) && (int'(bit_q) < PREFIX_BITS + DATA_BITS);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      bad_d   = bad_q;
      value_d = value_q;
      errc_d  = errc_q;
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      launch  = 1'b0;
      case (state_q)
         S_IDLE: launch = bus.i_enable | bus.i_single;
         S_SETUP: begin
            if (cnt_q == CW'(DIV_FACTOR - 1)) begin
               state_d = S_SHIFT;
               bit_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_SHIFT: begin
            if (sck_rise) begin
               if (in_data) shreg_d = DATA_BITS'({shreg_q, bus.i_sdo});
               else         bad_d   = bad_q | bus.i_sdo;
            end
            if (sck_hi_end) begin
               if (bit_q == BW'(N - 1)) begin
                  state_d = S_GAP;
                  cnt_d   = '0;
                  if (bad_q) begin
                     ferr_d = 1'b1;
                     if (errc_q != 8'hFF) errc_d = errc_q + 8'd1;
                  end else begin
                     value_d = shreg_q;
                     valid_d = 1'b1;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
         S_GAP: begin
            // Continuous mode chains straight into SETUP so CS stays high exactly GAP_CYCLES.
            if (cnt_q == CW'(GAP_CYCLES - 1)) begin
               if (bus.i_enable) launch  = 1'b1;
               else              state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (launch) begin
         state_d = S_SETUP;
         cnt_d   = '0;
         shreg_d = '0;
         bad_d   = 1'b0;
      end
      cs_d = !((state_d == S_SETUP) || (state_d == S_SHIFT));
   end

   assign sck_en = (state_d == S_SHIFT);

   always_ff @(posedge i_system_clock or negedge i_aresetn) begin
      if (!i_aresetn) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shreg_q <= '0;
         bad_q   <= 1'b0;
         value_q <= '0;
         errc_q  <= '0;
         cs_q    <= 1'b1;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         bad_q   <= bad_d;
         value_q <= value_d;
         errc_q  <= errc_d;
         cs_q    <= cs_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.o_cs        = cs_q;
   assign bus.o_value     = value_q;
   assign bus.o_valid     = valid_q;
   assign bus.o_frame_err = ferr_q;
   assign bus.o_err_count = errc_q;

endmodule

// File: tb/tb_spi_adc_capture.sv
// Directed bench for spi_adc_capture: a default instance (8-bit payload, DIV 2) and a
// DIV 1 / 12-bit instance, each fed by a simple ADC model that shifts on SCK falls.
module tb_spi_adc_capture;

   localparam int NA = 16;
   localparam int NB = 20;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a, rst_b;
   logic sdo_a = 1'b0;
   logic sdo_b = 1'b0;
   logic [31:0] frm_a, frm_b;
   int idx_a = 0;
   int idx_b = 0;

   spi_adc_capture_if #(.DATA_BITS(8))  ifa ();
   spi_adc_capture_if #(.DATA_BITS(12)) ifb ();

   spi_adc_capture u_a (.i_system_clock(clk), .i_aresetn(rst_a), .bus(ifa));
   spi_adc_capture #(.DIV_FACTOR(1), .DATA_BITS(12)) u_b (
      .i_system_clock(clk), .i_aresetn(rst_b), .bus(ifb));

   assign ifa.i_sdo = sdo_a;
   assign ifb.i_sdo = sdo_b;

   // ADC model: CS fall rewinds the frame, each SCK fall presents the next bit.
   always @(negedge ifa.o_cs or negedge ifa.o_sck) begin
      if (ifa.o_sck) idx_a = 0;
      else if (!ifa.o_cs && idx_a < NA) begin
         sdo_a = frm_a[NA-1-idx_a];
         idx_a++;
      end
   end

   always @(negedge ifb.o_cs or negedge ifb.o_sck) begin
      if (ifb.o_sck) idx_b = 0;
      else if (!ifb.o_cs && idx_b < NB) begin
         sdo_b = frm_b[NB-1-idx_b];
         idx_b++;
      end
   end

   int nval_a = 0, nerr_a = 0, nval_b = 0;
   always @(negedge clk) begin
      if (ifa.o_valid)     nval_a <= nval_a + 1;
      if (ifa.o_frame_err) nerr_a <= nerr_a + 1;
      if (ifb.o_valid)     nval_b <= nval_b + 1;
   end

   int n_tests = 0, n_fail = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic single_a(input logic [31:0] f);
      frm_a = f;
      @(negedge clk);
      ifa.i_single = 1'b1;
      @(negedge clk);
      ifa.i_single = 1'b0;
   endtask

   // Waits (bounded) for CS low, counts low cycles, returns on the first CS-high cycle.
   task automatic low_a(output int lowc);
      int w;
      w = 0;
      while (ifa.o_cs && w < 50) begin @(negedge clk); w++; end
      lowc = 0;
      while (!ifa.o_cs && lowc < 500) begin lowc++; @(negedge clk); end
   endtask

   task automatic high_a(output int hc);
      hc = 0;
      while (ifa.o_cs && hc < 100) begin hc++; @(negedge clk); end
   endtask

   task automatic high_b(output int hc);
      hc = 0;
      while (ifb.o_cs && hc < 100) begin hc++; @(negedge clk); end
   endtask

   typedef struct {
      logic [15:0] frame;
      logic        exp_valid;
      logic        exp_err;
      logic [7:0]  exp_value;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vecs[7];

   initial begin
      int lc, hc, b0, e0;
      rst_a = 1'b0; rst_b = 1'b0;
      ifa.i_enable = 1'b0; ifa.i_single = 1'b0;
      ifb.i_enable = 1'b0; ifb.i_single = 1'b0;
      frm_a = '0; frm_b = '0;

      vecs[0] = '{{3'b000, 8'hA5, 5'b00000}, 1'b1, 1'b0, 8'hA5, 8'd0};
      vecs[1] = '{{3'b010, 8'h3C, 5'b00000}, 1'b0, 1'b1, 8'hA5, 8'd1};
      vecs[2] = '{{3'b000, 8'hFF, 5'b00000}, 1'b1, 1'b0, 8'hFF, 8'd1};
      vecs[3] = '{{3'b000, 8'h00, 5'b00001}, 1'b0, 1'b1, 8'hFF, 8'd2};
      vecs[4] = '{{3'b000, 8'h00, 5'b00000}, 1'b1, 1'b0, 8'h00, 8'd2};
      vecs[5] = '{{3'b100, 8'h5A, 5'b10000}, 1'b0, 1'b1, 8'h00, 8'd3};
      vecs[6] = '{{3'b000, 8'h81, 5'b00000}, 1'b1, 1'b0, 8'h81, 8'd3};

      repeat (2) @(negedge clk);
      check("rst_cs",    32'(ifa.o_cs), 32'd1);
      check("rst_sck",   32'(ifa.o_sck), 32'd1);
      check("rst_value", 32'(ifa.o_value), 32'd0);
      check("rst_valid", 32'(ifa.o_valid), 32'd0);
      check("rst_ferr",  32'(ifa.o_frame_err), 32'd0);
      check("rst_errc",  32'(ifa.o_err_count), 32'd0);
      rst_a = 1'b1; rst_b = 1'b1;
      repeat (10) @(negedge clk);
      check("idle_no_start", 32'(ifa.o_cs), 32'd1);

      for (int i = 0; i < 7; i++) begin
         b0 = nval_a;
         single_a(32'(vecs[i].frame));
         low_a(lc);
         check($sformatf("v%0d_cs_low", i), 32'(lc), 32'd66);
         check($sformatf("v%0d_valid", i), 32'(ifa.o_valid), 32'(vecs[i].exp_valid));
         check($sformatf("v%0d_ferr", i), 32'(ifa.o_frame_err), 32'(vecs[i].exp_err));
         check($sformatf("v%0d_value", i), 32'(ifa.o_value), 32'(vecs[i].exp_value));
         check($sformatf("v%0d_errc", i), 32'(ifa.o_err_count), 32'(vecs[i].exp_cnt));
         repeat (8) @(negedge clk);
         check($sformatf("v%0d_valid_pulses", i), 32'(nval_a - b0), 32'(vecs[i].exp_valid));
      end

      // Reset during bit 7 (cs-low cycle 30 is its low half).
      single_a({16'd0, 3'b000, 8'hA5, 5'b00000});
      repeat (30) @(negedge clk);
      check("mid_sck_low", 32'(ifa.o_sck), 32'd0);
      check("mid_cs_low",  32'(ifa.o_cs), 32'd0);
      rst_a = 1'b0;
      #1;
      check("mid_rst_cs",    32'(ifa.o_cs), 32'd1);
      check("mid_rst_sck",   32'(ifa.o_sck), 32'd1);
      check("mid_rst_value", 32'(ifa.o_value), 32'd0);
      check("mid_rst_valid", 32'(ifa.o_valid), 32'd0);
      check("mid_rst_errc",  32'(ifa.o_err_count), 32'd0);
      repeat (3) @(negedge clk);
      rst_a = 1'b1;
      b0 = nval_a;
      high_a(hc);
      check("post_rst_idle", 32'(hc), 32'd100);
      check("post_rst_no_valid", 32'(nval_a - b0), 32'd0);
      single_a({16'd0, 3'b000, 8'h3C, 5'b00000});
      low_a(lc);
      check("post_rst_cs_low", 32'(lc), 32'd66);
      check("post_rst_value", 32'(ifa.o_value), 32'h3C);
      repeat (8) @(negedge clk);

      // Enable and single together start one frame only.
      frm_a = {16'd0, 3'b000, 8'h5A, 5'b00000};
      b0 = nval_a;
      @(negedge clk);
      ifa.i_enable = 1'b1; ifa.i_single = 1'b1;
      @(negedge clk);
      ifa.i_enable = 1'b0; ifa.i_single = 1'b0;
      low_a(lc);
      check("both_cs_low", 32'(lc), 32'd66);
      check("both_value", 32'(ifa.o_value), 32'h5A);
      high_a(hc);
      check("both_one_frame", 32'(hc), 32'd100);
      check("both_valid_pulses", 32'(nval_a - b0), 32'd1);

      // Continuous mode for three frames; enable dropped during the third.
      frm_a = {16'd0, 3'b000, 8'hA5, 5'b00000};
      b0 = nval_a;
      ifa.i_enable = 1'b1;
      low_a(lc);  check("cont_low0", 32'(lc), 32'd66);
      high_a(hc); check("cont_gap0", 32'(hc), 32'd4);
      low_a(lc);  check("cont_low1", 32'(lc), 32'd66);
      high_a(hc); check("cont_gap1", 32'(hc), 32'd4);
      ifa.i_enable = 1'b0;
      low_a(lc);  check("cont_low2", 32'(lc), 32'd66);
      high_a(hc); check("cont_stop", 32'(hc), 32'd100);
      check("cont_valid_pulses", 32'(nval_a - b0), 32'd3);

      // 256 bad frames saturate the error counter.
      e0 = nerr_a;
      for (int i = 0; i < 256; i++) begin
         single_a({16'd0, 3'b001, 8'h77, 5'b00000});
         low_a(lc);
         repeat (6) @(negedge clk);
         if (i == 254) check("sat_reach_255", 32'(ifa.o_err_count), 32'd255);
      end
      check("sat_hold_255", 32'(ifa.o_err_count), 32'd255);
      check("sat_err_pulses", 32'(nerr_a - e0), 32'd256);
      check("sat_value_held", 32'(ifa.o_value), 32'hA5);

      // DIV 1, 12-bit payload, with a single pulse during SHIFT that must be ignored.
      frm_b = {12'd0, 3'b000, 12'hABC, 5'b00000};
      b0 = nval_b;
      @(negedge clk);
      ifb.i_single = 1'b1;
      @(negedge clk);
      ifb.i_single = 1'b0;
      lc = 0;
      while (!ifb.o_cs && lc < 500) begin
         lc++;
         ifb.i_single = (lc == 10);
         @(negedge clk);
      end
      ifb.i_single = 1'b0;
      check("b_cs_low", 32'(lc), 32'd41);
      check("b_valid", 32'(ifb.o_valid), 32'd1);
      check("b_value", 32'(ifb.o_value), 32'hABC);
      high_b(hc);
      check("b_pulse_ignored", 32'(hc), 32'd100);
      check("b_valid_pulses", 32'(nval_b - b0), 32'd1);

      frm_b = {12'd0, 3'b000, 12'h5A3, 5'b00100};
      @(negedge clk);
      ifb.i_single = 1'b1;
      @(negedge clk);
      ifb.i_single = 1'b0;
      lc = 0;
      while (!ifb.o_cs && lc < 500) begin lc++; @(negedge clk); end
      check("b_bad_cs_low", 32'(lc), 32'd41);
      check("b_bad_ferr", 32'(ifb.o_frame_err), 32'd1);
      check("b_bad_value", 32'(ifb.o_value), 32'hABC);
      check("b_bad_errc", 32'(ifb.o_err_count), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
